// File: rtl/apu_cluster_package.sv
// Shared APU cluster constants and types.
// Used by the div/sqrt dispatch logic.
package apu_cluster_package;

  localparam int FP_WIDTH         = 32;
  localparam int NDSFLAGS_DIVSQRT = 3;
  localparam int NUSFLAGS_DIVSQRT = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } divsqrt_disp_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int NCORES = 4,
  parameter int IDXW   = $clog2(NCORES)
) (
  input  logic [NCORES-1:0] req_i,
  input  logic [IDXW-1:0]   ptr_i,
  output logic [NCORES-1:0] gnt_o,
  output logic [IDXW-1:0]   idx_o,
  output logic              any_o
);

  int j;

  assign any_o = |req_i;

  // Scan from farthest to nearest so the nearest hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    j     = 0;
    for (int i = NCORES - 1; i >= 0; i--) begin
      j = int'(ptr_i) + i;
      if (j >= NCORES) j = j - NCORES;
      if (req_i[j]) begin
        gnt_o = NCORES'(1) << j;
        idx_o = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/apu_divsqrt_dispatch.sv
// Round-robin dispatch of core div/sqrt requests to one
// shared iterative unit, with tag-based result routing.
module apu_divsqrt_dispatch #(
  parameter int NCORES     = 4,
  parameter int TAG_WIDTH  = 4,
  parameter int FP_WIDTH   = apu_cluster_package::FP_WIDTH,
  parameter int RND_WIDTH  = apu_cluster_package::NDSFLAGS_DIVSQRT,
  parameter int STAT_WIDTH = apu_cluster_package::NUSFLAGS_DIVSQRT
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NCORES-1:0]                  req_i,
  input  logic [NCORES-1:0][FP_WIDTH-1:0]    opa_i,
  input  logic [NCORES-1:0][FP_WIDTH-1:0]    opb_i,
  input  logic [NCORES-1:0]                  sqrt_i,
  input  logic [NCORES-1:0][RND_WIDTH-1:0]   rnd_i,
  output logic [NCORES-1:0]                  gnt_o,
  output logic [NCORES-1:0]                  rvalid_o,
  output logic [FP_WIDTH-1:0]                result_o,
  output logic [STAT_WIDTH-1:0]              status_o,
  output logic                               tag_err_o,
  output logic                               unit_en_o,
  output logic [FP_WIDTH-1:0]                unit_opa_o,
  output logic [FP_WIDTH-1:0]                unit_opb_o,
  output logic                               unit_sqrt_o,
  output logic [TAG_WIDTH-1:0]               unit_tag_o,
  output logic [RND_WIDTH-1:0]               unit_rnd_o,
  input  logic                               unit_ready_i,
  input  logic                               unit_valid_i,
  input  logic [FP_WIDTH-1:0]                unit_res_i,
  input  logic [TAG_WIDTH-1:0]               unit_tag_i,
  input  logic [STAT_WIDTH-1:0]              unit_status_i
);

  import apu_cluster_package::*;

  localparam int IDXW = $clog2(NCORES);
  localparam logic [TAG_WIDTH:0] NC_TAG = (TAG_WIDTH+1)'(NCORES);

  divsqrt_disp_state_t state_q, state_d;

  logic [IDXW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [TAG_WIDTH-1:0]  inflight_q, inflight_d;
  logic [NCORES-1:0]     rvalid_q, rvalid_d;
  logic [FP_WIDTH-1:0]   result_q, result_d;
  logic [STAT_WIDTH-1:0] status_q, status_d;
  logic                  err_q, err_d;

  logic [NCORES-1:0] win_gnt;
  logic [IDXW-1:0]   win_idx;
  logic              win_any;
  logic              grant;

  rr_arbiter #(
    .NCORES(NCORES),
    .IDXW  (IDXW)
  ) i_arb (
    .req_i(req_i),
    .ptr_i(rr_ptr_q),
    .gnt_o(win_gnt),
    .idx_o(win_idx),
    .any_o(win_any)
  );

  assign grant = (state_q == IDLE) & win_any & unit_ready_i;

  // Unit inputs are zeroed when idle to keep the bus quiet.
  assign gnt_o       = grant ? win_gnt : '0;
  assign unit_en_o   = grant;
  assign unit_opa_o  = grant ? opa_i[win_idx] : '0;
  assign unit_opb_o  = grant ? opb_i[win_idx] : '0;
  assign unit_sqrt_o = grant & sqrt_i[win_idx];
  assign unit_rnd_o  = grant ? rnd_i[win_idx] : '0;
  assign unit_tag_o  = grant ? TAG_WIDTH'(win_idx) : '0;

  assign rvalid_o  = rvalid_q;
  assign result_o  = result_q;
  assign status_o  = status_q;
  assign tag_err_o = err_q;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    inflight_d = inflight_q;
    rvalid_d   = '0;
    result_d   = result_q;
    status_d   = status_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (unit_valid_i) err_d = 1'b1;
        if (grant) begin
          state_d    = BUSY;
          inflight_d = TAG_WIDTH'(win_idx);
          rr_ptr_d   = (win_idx == IDXW'(NCORES - 1)) ?
                       '0 : win_idx + 1'b1;
        end
      end
      BUSY: begin
        if (unit_valid_i) begin
          state_d = IDLE;
          // Route by our own record, not the unit's tag.
          if ({1'b0, unit_tag_i} >= NC_TAG) begin
            err_d = 1'b1;
          end else begin
            rvalid_d = NCORES'(1) << inflight_q;
            result_d = unit_res_i;
            status_d = unit_status_i;
            if (unit_tag_i != inflight_q) err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      inflight_q <= '0;
      rvalid_q   <= '0;
      result_q   <= '0;
      status_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      inflight_q <= inflight_d;
      rvalid_q   <= rvalid_d;
      result_q   <= result_d;
      status_q   <= status_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_apu_divsqrt_dispatch.sv
// Self-checking bench for apu_divsqrt_dispatch with a
// cyclic-priority reference model and a scripted unit.
module tb_apu_divsqrt_dispatch;

  import apu_cluster_package::*;

  localparam int NC = 4;
  localparam int TW = 4;
  localparam int FW = FP_WIDTH;
  localparam int RW = NDSFLAGS_DIVSQRT;
  localparam int SW = NUSFLAGS_DIVSQRT;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic [NC-1:0] req_i = '0;
  logic [NC-1:0][FW-1:0] opa_i = '0;
  logic [NC-1:0][FW-1:0] opb_i = '0;
  logic [NC-1:0] sqrt_i = '0;
  logic [NC-1:0][RW-1:0] rnd_i = '0;
  logic [NC-1:0] gnt_o, rvalid_o;
  logic [FW-1:0] result_o, unit_opa_o, unit_opb_o;
  logic [SW-1:0] status_o;
  logic tag_err_o, unit_en_o, unit_sqrt_o;
  logic [TW-1:0] unit_tag_o;
  logic [RW-1:0] unit_rnd_o;
  logic unit_ready_i = 1'b0;
  logic unit_valid_i = 1'b0;
  logic [FW-1:0] unit_res_i = '0;
  logic [TW-1:0] unit_tag_i = '0;
  logic [SW-1:0] unit_status_i = '0;

  int checks = 0;
  int errors = 0;
  int mptr = 0;

  always #5 clk_i = ~clk_i;

  apu_divsqrt_dispatch #(
    .NCORES(NC), .TAG_WIDTH(TW), .FP_WIDTH(FW),
    .RND_WIDTH(RW), .STAT_WIDTH(SW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_i(req_i), .opa_i(opa_i), .opb_i(opb_i),
    .sqrt_i(sqrt_i), .rnd_i(rnd_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .result_o(result_o), .status_o(status_o),
    .tag_err_o(tag_err_o), .unit_en_o(unit_en_o),
    .unit_opa_o(unit_opa_o), .unit_opb_o(unit_opb_o),
    .unit_sqrt_o(unit_sqrt_o), .unit_tag_o(unit_tag_o),
    .unit_rnd_o(unit_rnd_o), .unit_ready_i(unit_ready_i),
    .unit_valid_i(unit_valid_i), .unit_res_i(unit_res_i),
    .unit_tag_i(unit_tag_i), .unit_status_i(unit_status_i)
  );

  // Reference rule: first requester at or after the pointer.
  function automatic int pick(input logic [NC-1:0] r,
                              input int p);
    for (int i = 0; i < NC; i++)
      if (r[(p + i) % NC]) return (p + i) % NC;
    return -1;
  endfunction

  function automatic logic [NC-1:0] onehot(input int w);
    logic [NC-1:0] v;
    v = '0;
    if (w >= 0) v[w] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    req_i = '0;
    sqrt_i = '0;
    unit_ready_i = 1'b0;
    unit_valid_i = 1'b0;
    repeat (2) tick();
    rst_ni = 1'b1;
    mptr = 0;
  endtask

  // Scripted unit: completes lat cycles after start.
  task automatic serve(input int lat, input logic [FW-1:0] r,
                       input logic [SW-1:0] s,
                       input logic [TW-1:0] t);
    repeat (lat - 1) tick();
    unit_valid_i = 1'b1;
    unit_res_i = r;
    unit_status_i = s;
    unit_tag_i = t;
    tick();
    unit_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    req_i = '0;
    #1;
    checks++;
    if ({gnt_o, rvalid_o, unit_en_o, tag_err_o} !== '0) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 0",
               {gnt_o, rvalid_o, unit_en_o, tag_err_o});
    end
    checks++;
    if ({result_o, status_o} !== '0) begin
      errors++;
      $display("FAIL reset_res: got %h/%h want 0",
               result_o, status_o);
    end
    checks++;
    if ({unit_opa_o, unit_opb_o, unit_tag_o, unit_rnd_o,
         unit_sqrt_o} !== '0) begin
      errors++;
      $display("FAIL reset_unit: got %h %h %h want 0",
               unit_opa_o, unit_opb_o, unit_tag_o);
    end
    tick();
    rst_ni = 1'b1;
    mptr = 0;
  endtask

  task automatic test_single();
    do_reset();
    req_i = 4'b0010;
    opa_i[1] = 32'h4000_0000;
    opb_i[1] = 32'h3F80_0000;
    unit_ready_i = 1'b1;
    #1;
    checks++;
    if (gnt_o !== 4'b0010 || unit_en_o !== 1'b1) begin
      errors++;
      $display("FAIL single_gnt: got %b/%b want 0010/1",
               gnt_o, unit_en_o);
    end
    checks++;
    if (unit_tag_o !== 4'd1 || unit_opa_o !== 32'h4000_0000 ||
        unit_opb_o !== 32'h3F80_0000) begin
      errors++;
      $display("FAIL single_ops: got %h %h %h want 1 40000000 3f800000",
               unit_tag_o, unit_opa_o, unit_opb_o);
    end
    tick();
    mptr = 2;
    req_i = '0;
    checks++;
    if (gnt_o !== '0 || unit_en_o !== 1'b0) begin
      errors++;
      $display("FAIL busy_nogrant: got %b/%b want 0/0",
               gnt_o, unit_en_o);
    end
    serve(3, 32'h4000_0000, '0, 4'd1);
    checks++;
    if (rvalid_o !== 4'b0010 || result_o !== 32'h4000_0000) begin
      errors++;
      $display("FAIL single_ret: got %b %h want 0010 40000000",
               rvalid_o, result_o);
    end
    tick();
    checks++;
    if (rvalid_o !== '0 || result_o !== 32'h4000_0000 ||
        tag_err_o !== 1'b0) begin
      errors++;
      $display("FAIL single_hold: got %b %h %b want 0 40000000 0",
               rvalid_o, result_o, tag_err_o);
    end
  endtask

  task automatic test_fairness();
    int order [5];
    order = '{0, 1, 2, 3, 0};
    do_reset();
    req_i = 4'b1111;
    unit_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      int w;
      #1;
      w = pick(req_i, mptr);
      checks++;
      if (gnt_o !== onehot(w) || w != order[k]) begin
        errors++;
        $display("FAIL fair_%0d: got %b want %b", k, gnt_o,
                 onehot(order[k]));
      end
      mptr = (w + 1) % NC;
      tick();
      serve(10, 32'(k), '0, 4'(w));
      checks++;
      if (rvalid_o !== onehot(w) || result_o !== 32'(k)) begin
        errors++;
        $display("FAIL fair_ret_%0d: got %b %h want %b %h", k,
                 rvalid_o, result_o, onehot(w), 32'(k));
      end
    end
    req_i = '0;
    tick();
  endtask

  task automatic test_not_ready();
    do_reset();
    req_i = 4'b0001;
    unit_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (gnt_o !== '0 || unit_en_o !== 1'b0) begin
        errors++;
        $display("FAIL notready_%0d: got %b/%b want 0/0", k,
                 gnt_o, unit_en_o);
      end
      tick();
    end
    unit_ready_i = 1'b1;
    #1;
    checks++;
    if (gnt_o !== 4'b0001 || unit_en_o !== 1'b1) begin
      errors++;
      $display("FAIL ready_gnt: got %b/%b want 0001/1",
               gnt_o, unit_en_o);
    end
    tick();
    req_i = '0;
    serve(2, 32'h1234_5678, '0, 4'd0);
    checks++;
    if (rvalid_o !== 4'b0001 || result_o !== 32'h1234_5678) begin
      errors++;
      $display("FAIL ready_ret: got %b %h want 0001 12345678",
               rvalid_o, result_o);
    end
    tick();
  endtask

  task automatic test_tag_err();
    do_reset();
    req_i = 4'b0100;
    unit_ready_i = 1'b1;
    tick();
    req_i = '0;
    serve(2, 32'hCAFE_0002, '0, 4'd3);
    checks++;
    if (rvalid_o !== 4'b0100 || tag_err_o !== 1'b1) begin
      errors++;
      $display("FAIL tag_mismatch: got %b/%b want 0100/1",
               rvalid_o, tag_err_o);
    end
    repeat (3) tick();
    checks++;
    if (tag_err_o !== 1'b1) begin
      errors++;
      $display("FAIL tag_sticky: got %b want 1", tag_err_o);
    end
    do_reset();
    unit_valid_i = 1'b1;
    unit_tag_i = 4'd0;
    tick();
    unit_valid_i = 1'b0;
    checks++;
    if (tag_err_o !== 1'b1 || rvalid_o !== '0) begin
      errors++;
      $display("FAIL spurious: got %b/%b want 1/0",
               tag_err_o, rvalid_o);
    end
    do_reset();
    req_i = 4'b0001;
    unit_ready_i = 1'b1;
    tick();
    req_i = '0;
    serve(1, 32'hDEAD_BEEF, '0, 4'd9);
    checks++;
    if (rvalid_o !== '0 || tag_err_o !== 1'b1) begin
      errors++;
      $display("FAIL tag_range: got %b/%b want 0/1",
               rvalid_o, tag_err_o);
    end
    req_i = 4'b1000;
    #1;
    checks++;
    if (gnt_o !== 4'b1000) begin
      errors++;
      $display("FAIL range_idle: got %b want 1000", gnt_o);
    end
    tick();
    req_i = '0;
    serve(1, '0, '0, 4'd3);
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_i = 4'b0010;
    unit_ready_i = 1'b1;
    tick();
    req_i = '0;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({gnt_o, rvalid_o, unit_en_o, tag_err_o} !== '0 ||
        result_o !== '0 || status_o !== '0) begin
      errors++;
      $display("FAIL midreset_out: got %b %h want 0",
               {gnt_o, rvalid_o, unit_en_o, tag_err_o}, result_o);
    end
    repeat (2) tick();
    rst_ni = 1'b1;
    mptr = 0;
    unit_valid_i = 1'b1;
    unit_tag_i = 4'd1;
    tick();
    unit_valid_i = 1'b0;
    checks++;
    if (tag_err_o !== 1'b1 || rvalid_o !== '0) begin
      errors++;
      $display("FAIL late_valid: got %b/%b want 1/0",
               tag_err_o, rvalid_o);
    end
    req_i = 4'b1010;
    #1;
    checks++;
    if (gnt_o !== onehot(pick(req_i, mptr))) begin
      errors++;
      $display("FAIL post_reset_gnt: got %b want %b", gnt_o,
               onehot(pick(req_i, mptr)));
    end
    tick();
    req_i = '0;
    serve(2, 32'h0BAD_F00D, '0, 4'd1);
    checks++;
    if (rvalid_o !== 4'b0010 || result_o !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL post_reset_ret: got %b %h want 0010 0badf00d",
               rvalid_o, result_o);
    end
    tick();
  endtask

  task automatic test_sqrt_flag();
    do_reset();
    req_i = 4'b0001;
    sqrt_i = 4'b0001;
    rnd_i[0] = 3'b010;
    opa_i[0] = 32'h4080_0000;
    opb_i[0] = 32'h1111_2222;
    unit_ready_i = 1'b1;
    #1;
    checks++;
    if (unit_sqrt_o !== 1'b1 || unit_rnd_o !== 3'b010 ||
        unit_opb_o !== 32'h1111_2222) begin
      errors++;
      $display("FAIL sqrt_drive: got %b %b %h want 1 010 11112222",
               unit_sqrt_o, unit_rnd_o, unit_opb_o);
    end
    tick();
    req_i = '0;
    sqrt_i = '0;
    serve(4, 32'h4000_0000, 5'b01000, 4'd0);
    checks++;
    if (rvalid_o !== 4'b0001 || status_o !== 5'b01000) begin
      errors++;
      $display("FAIL sqrt_status: got %b %b want 0001 01000",
               rvalid_o, status_o);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 40; n++) begin
      logic [NC-1:0] m;
      logic [FW-1:0] r;
      logic [SW-1:0] s;
      int w, lat, dly;
      m = 4'($urandom_range(1, 15));
      for (int c = 0; c < NC; c++) begin
        opa_i[c] = $urandom;
        opb_i[c] = $urandom;
        sqrt_i[c] = 1'($urandom);
        rnd_i[c] = 3'($urandom);
      end
      dly = $urandom_range(0, 2);
      req_i = m;
      unit_ready_i = 1'b0;
      repeat (dly) begin
        #1;
        checks++;
        if (gnt_o !== '0) begin
          errors++;
          $display("FAIL rnd_noready_%0d: got %b want 0", n, gnt_o);
        end
        tick();
      end
      unit_ready_i = 1'b1;
      #1;
      w = pick(m, mptr);
      checks++;
      if (gnt_o !== onehot(w) || unit_tag_o !== 4'(w) ||
          unit_opa_o !== opa_i[w] || unit_opb_o !== opb_i[w] ||
          unit_sqrt_o !== sqrt_i[w] || unit_rnd_o !== rnd_i[w]) begin
        errors++;
        $display("FAIL rnd_gnt_%0d: got %b tag %0d want %b tag %0d",
                 n, gnt_o, unit_tag_o, onehot(w), w);
      end
      mptr = (w + 1) % NC;
      tick();
      req_i = '0;
      lat = $urandom_range(1, 6);
      r = $urandom;
      s = 5'($urandom);
      serve(lat, r, s, 4'(w));
      checks++;
      if (rvalid_o !== onehot(w) || result_o !== r ||
          status_o !== s) begin
        errors++;
        $display("FAIL rnd_ret_%0d: got %b %h %b want %b %h %b", n,
                 rvalid_o, result_o, status_o, onehot(w), r, s);
      end
    end
    checks++;
    if (tag_err_o !== 1'b0) begin
      errors++;
      $display("FAIL rnd_tagerr: got %b want 0", tag_err_o);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_not_ready();
    test_tag_err();
    test_reset_mid();
    test_sqrt_flag();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
